// File: rtl/demux_1to4_buf_if.sv
// Stream bundle for demux_1to4_buf: one upstream valid/ready port and four
// downstream valid/ready channels. The slave modport is the demux side.
interface demux_1to4_buf_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] src;
    logic [1:0]       select;
    logic             src_valid;
    logic             src_ready;

    logic [WIDTH-1:0] result1;
    logic [WIDTH-1:0] result2;
    logic [WIDTH-1:0] result3;
    logic [WIDTH-1:0] result4;
    logic             valid1;
    logic             valid2;
    logic             valid3;
    logic             valid4;
    logic             ready1;
    logic             ready2;
    logic             ready3;
    logic             ready4;

    modport master (
        output src, select, src_valid,
        output ready1, ready2, ready3, ready4,
        input  src_ready,
        input  result1, result2, result3, result4,
        input  valid1, valid2, valid3, valid4
    );

    modport slave (
        input  src, select, src_valid,
        input  ready1, ready2, ready3, ready4,
        output src_ready,
        output result1, result2, result3, result4,
        output valid1, valid2, valid3, valid4
    );
endinterface

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 stream demultiplexer with one register slot per channel.
// Define DEMUX_STATS_EN to add the per-channel saturating drain counters on `count`.
module demux_1to4_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    demux_1to4_buf_if.slave  bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [31:0]      count
`endif
);

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;

    logic [3:0] w_ready;
    logic [3:0] w_load;
    logic [3:0] w_drain;
    logic       w_src_ready;
    logic       w_accept;

    always_comb begin
        w_ready = {bus.ready4, bus.ready3, bus.ready2, bus.ready1};
    end

    // Only the addressed slot gates acceptance; src_valid is deliberately absent here.
    always_comb begin
        w_src_ready = rst_n && (!r_valid[bus.select] || w_ready[bus.select]);
        w_accept    = bus.src_valid && w_src_ready;
    end

    always_comb begin
        w_load  = '0;
        w_drain = r_valid & w_ready;
        if (w_accept) begin
            w_load[bus.select] = 1'b1;
        end
    end

    // A refill wins over a drain so a same-cycle drain+load leaves no bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k]  <= bus.src;
                    r_valid[k] <= 1'b1;
                end else if (w_drain[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.src_ready = w_src_ready;
    assign bus.result1   = r_data[0];
    assign bus.result2   = r_data[1];
    assign bus.result3   = r_data[2];
    assign bus.result4   = r_data[3];
    assign bus.valid1    = r_valid[0];
    assign bus.valid2    = r_valid[1];
    assign bus.valid3    = r_valid[2];
    assign bus.valid4    = r_valid[3];

`ifdef DEMUX_STATS_EN
    logic [7:0] r_cnt [4];

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_drain[k] && (r_cnt[k] != 8'hFF)) begin
                    r_cnt[k] <= r_cnt[k] + 8'd1;
                end
            end
        end
    end

    assign count = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: doc/demux_1to4_buf.md
# demux_1to4_buf

- Buffered 1-to-4 stream demultiplexer: the distribution counterpart of the 4:1 source-select mux in the Lab2 datapath.
- Accepts one word per handshake on a single input stream and steers it, by a 2-bit `select`, into one of four independent single-entry output registers.
- Each output has its own valid/ready handshake, so a stalled sink blocks only the words addressed to it.

## Interface
- `WIDTH`, default 32: data width of `src` and every `resultN`.
- `clk_i` input, 1 bit: clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `src` input, WIDTH bits: input data word.
- `select` input, 2 bits: destination channel. 0 → `result1`, 1 → `result2`, 2 → `result3`, 3 → `result4`.
- `src_valid` input, 1 bit: `src` and `select` hold a word.
- `src_ready` output, 1 bit: block accepts the word this cycle (combinational).
- `result1`..`result4` output, WIDTH bits each: registered output data per channel.
- `valid1`..`valid4` output, 1 bit each: channel register holds a word.
- `ready1`..`ready4` input, 1 bit each: sink consumes the channel word this cycle.
- `count` output, 32 bits: present only with `DEMUX_STATS_EN`. Bits [8k+7:8k] are the counter for channel k+1.

## Operation
- Channel k state: data register `resultk` and flag `validk`.
- Output handshake on channel k: `validk && readyk` at a rising edge.
- `src_ready = !valid[select] || ready[select]`, i.e. the target slot is empty or drains this cycle.
  - Depends only on the addressed channel; the other three have no effect.
- Input handshake: `src_valid && src_ready` at a rising edge. On it: `result[select] <= src`, `valid[select] <= 1`.
- Channel k with an output handshake and no refill that cycle: `validk <= 0`, `resultk` keeps its old value.
- Simultaneous drain and refill of the same channel: new word loaded, `validk` stays 1, no bubble.
- Any subset of the four channels may drain in one cycle, independent of the input handshake.
- Upstream protocol:
  - Once `src_valid` is asserted, `src` and `select` are held stable, and `src_valid` stays high, until the handshake.
  - The block does not need to tolerate `select` changing while stalled.
- Order is preserved per channel. No ordering is guaranteed across channels.
- Head-of-line blocking: if the addressed channel is full and its sink is not ready, `src_ready` stays 0. Words for other channels wait behind it.
- `validk` never drops without an output handshake on channel k, and `resultk` never changes while `validk=1 && readyk=0`.
- Reset (`rst_n=0` at a rising edge, including mid-transfer):
  - All `validk` and `resultk` → 0; `count` → 0.
  - Buffered words are discarded.
  - While `rst_n=0`, `src_ready` is forced to 0.

## Timing
- Latency: a word accepted at edge t appears on `resultk` with `validk=1` immediately after edge t, i.e. one cycle.
- Throughput: one word per cycle, provided the addressed sink is ready or its slot is empty.
- `src_ready` is combinational from `select`, `validk` and `readyk`. There is no path from `src_valid` to `src_ready`.
- All outputs except `src_ready` are registered.
- First word after reset release is accepted on the first edge with `rst_n=1`.

## Configuration
- `DEMUX_STATS_EN` defined:
  - Adds the `count` port and four 8-bit counters.
  - Counter k increments on each output handshake of channel k and saturates at 255 (no wrap).
  - Counters reset to 0.
- `DEMUX_STATS_EN` undefined:
  - No `count` port and no counter logic.
  - Datapath and handshake behaviour are identical.

## Test plan
- Reset:
  - Stimulus: `rst_n=0` for 2 cycles with `src_valid=1`.
  - Required: `src_ready=0`, all `validk=0`, all `resultk=0`.
  - After release, `src=32'hA5` with `select=2` → `result3=32'hA5` and `valid3=1` one cycle later; other channels stay invalid.
- Steering:
  - Stimulus: words 1, 2, 3, 4 to `select` 0, 1, 2, 3 on consecutive cycles, all `readyk=1`.
  - Required: each appears on `result1`..`result4` respectively, each valid for exactly one cycle, `src_ready=1` throughout.
- Back-pressure:
  - Stimulus: `ready1=0`; send 10 then 11 to `select=0`.
  - Required: `result1` holds 10 stably and `src_ready=0` while the second word waits.
  - Raise `ready1` → 10 consumed and 11 loaded in the same cycle; `valid1` stays 1.
- Independence:
  - Stimulus: `ready1=0` with `valid1=1`; send 7 to `select=3`.
  - Required: accepted immediately; `result4=7`, `valid4=1`.
- Mid-operation reset:
  - Stimulus: all four channels full with `readyk=0`; assert `rst_n=0` for one cycle.
  - Required: all `validk=0` and all `resultk=0` on the next cycle.
- Stats (with `DEMUX_STATS_EN`):
  - Stimulus: 300 words to `select=1`, `ready2=1`.
  - Required: `count[15:8]=255` (saturated), other three counter fields 0.
